// File: rtl/stream_3d_to_1d_array.sv
// stream_3d_to_1d_array
// Packs a ROWS x COLS array of BIT_WIDTH-bit elements, received one element per
// handshake in row-major order, into a single flat bus. Element (r,c) is placed
// at flat index c*ROWS + r, so the row index varies fastest in the flat bus.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data/valid/ready  element input stream
//   out/out_valid/out_ready  flat array output with handshake
//   row_idx, col_idx  position of the next element to be written
//
// Build option:
//   STREAM_3D_TO_1D_DOUBLE_BUF_EN  separate fill buffer and output register so
//   the next frame can be collected while the previous one is still presented.
module stream_3d_to_1d_array #(
    parameter int unsigned BIT_WIDTH = 4,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [BIT_WIDTH-1:0]                        in_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [ROWS*COLS*BIT_WIDTH-1:0]              out,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0]    row_idx,
    output logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0]    col_idx
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    // FILL collects elements; HOLD (single buffer) / WAIT (double buffer)
    // means a complete frame is waiting for the consumer.
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]                  state;
    logic [0:0]                  state_next;
    logic                        accept;
    logic                        last_col;
    logic                        last_row;
    logic                        frame_done;
    logic                        out_fire;
    logic [IW-1:0]               wr_idx;
    logic [N-1:0][BIT_WIDTH-1:0] fill;
    logic [N-1:0][BIT_WIDTH-1:0] fill_next;

    // Gated by rst so no input handshake can complete during reset.
    assign in_ready   = (state == ST_FILL) && !rst;
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_col   = (col_idx == CW'(COLS - 1));
    assign last_row   = (row_idx == RW'(ROWS - 1));
    assign frame_done = accept && last_col && last_row;

    // Transposed placement: row index varies fastest in the flat bus.
    assign wr_idx = IW'(col_idx) * IW'(ROWS) + IW'(row_idx);

    // Fill buffer contents including the element accepted this cycle.
    always_comb begin
        fill_next = fill;
        if (accept) begin
            fill_next[wr_idx] = in_data;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: begin
`ifdef STREAM_3D_TO_1D_DOUBLE_BUF_EN
                if (frame_done && out_valid && !out_ready) begin
                    state_next = ST_HOLD;
                end
`else
                if (frame_done) begin
                    state_next = ST_HOLD;
                end
`endif
            end
            default: begin
                if (out_fire) begin
                    state_next = ST_FILL;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Row-major position counters; a size-1 dimension keeps its index at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (accept) begin
            col_idx <= last_col ? '0 : col_idx + CW'(1);
            if (last_col) begin
                row_idx <= last_row ? '0 : row_idx + RW'(1);
            end
        end
    end

`ifdef STREAM_3D_TO_1D_DOUBLE_BUF_EN
    // Separate fill buffer; completed frames are copied into out.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            fill <= fill_next;
            if (state == ST_HOLD) begin
                // Parked frame moves out as the current one is taken.
                if (out_ready) begin
                    out <= fill;
                end
            end else if (frame_done && (!out_valid || out_ready)) begin
                out       <= fill_next;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end
`else
    // Single assembly register doubles as the output.
    assign out = fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill      <= '0;
            out_valid <= 1'b0;
        end else begin
            fill <= fill_next;
            if (frame_done) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_3d_to_1d_array.sv
// Bench for stream_3d_to_1d_array: directed frames, reset, edge shapes and a
// randomized run, all compared against a frame-level reference model.
module tb_stream_3d_to_1d_array;

    localparam int unsigned BW   = 4;
    localparam int unsigned ROWS = 2;
    localparam int unsigned COLS = 3;
    localparam int unsigned N    = ROWS * COLS;
    localparam int unsigned FW   = N * BW;

    logic          clk;
    logic          rst;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          out_ready;

    logic          in_ready;
    logic [FW-1:0] out;
    logic          out_valid;
    logic [0:0]    row_idx;
    logic [1:0]    col_idx;

    logic          a_in_ready;
    logic [15:0]   a_out;
    logic          a_out_valid;
    logic [0:0]    a_row_idx;
    logic [1:0]    a_col_idx;

    logic          b_in_ready;
    logic [15:0]   b_out;
    logic          b_out_valid;
    logic [1:0]    b_row_idx;
    logic [0:0]    b_col_idx;

    stream_3d_to_1d_array #(.BIT_WIDTH(BW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .row_idx(row_idx), .col_idx(col_idx)
    );

    stream_3d_to_1d_array #(.BIT_WIDTH(BW), .ROWS(1), .COLS(4)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .out(a_out), .out_valid(a_out_valid),
        .out_ready(out_ready), .row_idx(a_row_idx), .col_idx(a_col_idx)
    );

    stream_3d_to_1d_array #(.BIT_WIDTH(BW), .ROWS(4), .COLS(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .out(b_out), .out_valid(b_out_valid),
        .out_ready(out_ready), .row_idx(b_row_idx), .col_idx(b_col_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: elements in arrival order, frame packed on completion.
    logic [BW-1:0] m_elem [N];
    int unsigned   m_count;
    logic          m_valid;
    logic          m_pend;
    logic [FW-1:0] m_out;
    logic [FW-1:0] m_pbuf;
    int unsigned   frames;

    function automatic logic [FW-1:0] pack_frame();
        logic [FW-1:0] v;
        int r;
        int c;
        v = '0;
        for (int k = 0; k < int'(N); k++) begin
            r = k / int'(COLS);
            c = k % int'(COLS);
            v[(c * int'(ROWS) + r) * int'(BW) +: BW] = m_elem[k];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_out   = '0;
        m_pbuf  = '0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance it.
    task automatic step(input logic v, input logic [BW-1:0] d, input logic ordy, input logic r);
        logic exp_ready;
        logic acc;
        logic done;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        #1;
`ifdef STREAM_3D_TO_1D_DOUBLE_BUF_EN
        exp_ready = !r && !m_pend;
`else
        exp_ready = !r && !m_valid;
`endif
        check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) check_eq("out", 64'(out), 64'(m_out));
        check_eq("row_idx", 64'(row_idx), 64'(m_count / COLS));
        check_eq("col_idx", 64'(col_idx), 64'(m_count % COLS));

        if (r) begin
            model_reset();
        end else begin
            acc  = v && exp_ready;
            done = 1'b0;
            if (acc) begin
                m_elem[m_count] = d;
                m_count++;
                if (m_count == N) begin
                    m_count = 0;
                    frames++;
                    done = 1'b1;
                end
            end
`ifdef STREAM_3D_TO_1D_DOUBLE_BUF_EN
            if (m_pend) begin
                if (ordy) begin
                    m_out  = m_pbuf;
                    m_pend = 1'b0;
                end
            end else if (done) begin
                if (!m_valid || ordy) begin
                    m_out   = pack_frame();
                    m_valid = 1'b1;
                end else begin
                    m_pbuf = pack_frame();
                    m_pend = 1'b1;
                end
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
`else
            if (m_valid) begin
                if (ordy) m_valid = 1'b0;
            end else if (done) begin
                m_out   = pack_frame();
                m_valid = 1'b1;
            end
`endif
        end
    endtask

    logic [BW-1:0] ev [4];
    int unsigned   f0;
    int unsigned   cyc;

    initial begin
        ev[0] = 4'hA; ev[1] = 4'hB; ev[2] = 4'hC; ev[3] = 4'hD;
        frames    = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset values while rst is held.
        step(1'b1, 4'h5, 1'b1, 1'b1);
        check_eq("rst_out", 64'(out), 64'h0);
        check_eq("rst_in_ready", 64'(in_ready), 64'h0);

        // Frame 1..6 with out_ready=1: one-cycle out_valid.
        for (int k = 1; k <= 6; k++) step(1'b1, BW'(k), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("t1_valid", 64'(out_valid), 64'h1);
        check_eq("t1_out", 64'(out), 64'h635241);
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("t1_valid_drop", 64'(out_valid), 64'h0);

        // Same frame held with out_ready=0 while extra elements are offered.
        for (int k = 1; k <= 6; k++) step(1'b1, BW'(k), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, BW'($urandom), 1'b0, 1'b0);
            check_eq("t2_out", 64'(out), 64'h635241);
`ifndef STREAM_3D_TO_1D_DOUBLE_BUF_EN
            check_eq("t2_in_ready", 64'(in_ready), 64'h0);
`endif
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
`ifndef STREAM_3D_TO_1D_DOUBLE_BUF_EN
        check_eq("t2_row0", 64'(row_idx), 64'h0);
        check_eq("t2_col0", 64'(col_idx), 64'h0);
`endif

        // Reset mid-frame, then a clean frame.
        for (int k = 9; k <= 11; k++) step(1'b1, BW'(k), 1'b1, 1'b0);
        step(1'b1, 4'hF, 1'b1, 1'b1);
        step(1'b1, 4'hF, 1'b1, 1'b1);
        check_eq("t4_rst_out", 64'(out), 64'h0);
        check_eq("t4_rst_valid", 64'(out_valid), 64'h0);
        for (int k = 1; k <= 6; k++) step(1'b1, BW'(k), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("t4_out", 64'(out), 64'h635241);

        // Edge shapes 1x4 and 4x1.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, ev[k], 1'b1, 1'b0);
            check_eq("a_in_ready", 64'(a_in_ready), 64'h1);
            check_eq("b_in_ready", 64'(b_in_ready), 64'h1);
            check_eq("a_row0", 64'(a_row_idx), 64'h0);
            check_eq("b_col0", 64'(b_col_idx), 64'h0);
            check_eq("a_col", 64'(a_col_idx), 64'(k));
            check_eq("b_row", 64'(b_row_idx), 64'(k));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("a_valid", 64'(a_out_valid), 64'h1);
        check_eq("a_out", 64'(a_out), 64'hDCBA);
        check_eq("b_valid", 64'(b_out_valid), 64'h1);
        check_eq("b_out", 64'(b_out), 64'hDCBA);
        check_eq("a_col_wrap", 64'(a_col_idx), 64'h0);
        check_eq("b_row_wrap", 64'(b_row_idx), 64'h0);

`ifdef STREAM_3D_TO_1D_DOUBLE_BUF_EN
        // Two frames back-to-back: 12 accepts with no in_ready gap.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, BW'(k), 1'b1, 1'b0);
            check_eq("db_in_ready", 64'(in_ready), 64'h1);
            if (k == 7) check_eq("db_out1", 64'(out), 64'h635241);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("db_out2", 64'(out), 64'hC9B8A7);
`endif

        // Randomized traffic: 50% in_valid, mostly-ready consumer.
        step(1'b0, '0, 1'b0, 1'b1);
        f0  = frames;
        cyc = 0;
        while ((frames - f0) < 20 && cyc < 3000) begin
            step(1'($urandom), BW'($urandom), 1'(($urandom % 4) != 0), 1'b0);
            cyc++;
        end
        check_eq("rand_frames_done", 64'((frames - f0) >= 20), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_3d_to_1d_array.md
# stream_3d_to_1d_array

Serial packer that collects a ROWS×COLS array of BIT_WIDTH-bit elements, one element per handshake, and presents the completed array as one flat bus. Elements arrive row by row. The flat bus uses the codebase's standard 1D array layout, so downstream logic can split it back into a 3D array directly. The block sits between element-serial producers (datapath outputs, memory readers) and blocks that consume whole flat arrays.

## Interface
Parameters:
- BIT_WIDTH, 4, width of one element
- ROWS, 8, number of rows; must be ≥1
- COLS, 8, number of columns; must be ≥1

Ports:
- clk  input  1  sole clock; all state changes on its rising edge
- rst  input  1  reset; synchronous and active-high
- in_data  input  BIT_WIDTH  element value
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block accepts in_data this cycle
- out  output  ROWS*COLS*BIT_WIDTH  packed array
- out_valid  output  1  out holds a complete array
- out_ready  input  1  consumer accepts out this cycle
- row_idx  output  $clog2(ROWS) (min 1)  row of the next element to be written
- col_idx  output  $clog2(COLS) (min 1)  column of the next element to be written

## Operation
- Input order is row-major: (r0,c0), (r0,c1) … (r0,cCOLS-1), (r1,c0) …
- An element is accepted when in_valid && in_ready on a clock edge.
- Element (r,c) is written to out bits [(c*ROWS + r)*BIT_WIDTH +: BIT_WIDTH]. The row index varies fastest in the flat bus, so the block transposes placement relative to arrival order.
- Counters:
  - col_idx increments on each accept.
  - When col_idx wraps from COLS-1 to 0, row_idx increments.
  - When row_idx wraps from ROWS-1 to 0, the frame is complete.
  - When COLS=1 or ROWS=1, the corresponding index is held at 0.
- State machine, single-buffer build:
  - FILL: in_ready=1, out_valid=0. Accepting element (ROWS-1,COLS-1) moves the block to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_valid && out_ready moves the block to FILL and resets both indices to 0.
- Elements not yet written in the current frame keep their previous-frame values. Consumers must only sample out while out_valid=1.
- Reset values: out=0, out_valid=0, row_idx=0, col_idx=0, state FILL.
  - in_ready=0 while rst=1 and 1 on the first cycle after rst deasserts.
- Reset mid-frame discards all partially collected elements and any held array. No handshake completes on a cycle where rst=1.

## Timing
- out_valid rises on the clock edge that accepts the last element, so it is visible the following cycle. Latency from last accept to out_valid is 1 cycle.
- out is stable while out_valid=1 && out_ready=0.
- Single-buffer build: in_ready is low for at least 1 cycle per frame, the HOLD cycle.
  - Frame period is ROWS*COLS+1 cycles minimum.
- out_ready arriving before out_valid has no effect.
- in_valid must not depend on in_ready. out_valid does not depend on out_ready.
- Throughput with the macro defined: 1 element per cycle sustained while out_ready=1.

## Configuration
- STREAM_3D_TO_1D_DOUBLE_BUF_EN
- Undefined: single assembly register that doubles as out; FILL/HOLD behaviour as above.
- Defined: a separate fill buffer and output register, with states FILL, WAIT.
  - Accepting the last element transfers the fill buffer, including the new element, into out. The transfer happens on that same edge if out_valid=0 or out_ready=1.
  - When the transfer happens, indices reset and in_ready stays 1, so the next frame can start on the next cycle.
  - Otherwise the block enters WAIT with in_ready=0. The transfer occurs on the edge where out_ready=1, then the block returns to FILL.
  - A simultaneous output accept and frame completion yields out_valid=1 continuously, with out updated to the new frame.

## Test plan
- BIT_WIDTH=4, ROWS=2, COLS=3; send 1,2,3,4,5,6 back-to-back with out_ready=1 → out=0x635241, out_valid for exactly 1 cycle, 1 cycle after the 6th accept.
- Same frame with out_ready=0 for 5 cycles → out holds 0x635241, in_ready=0 throughout, and extra in_valid pulses are ignored; the next frame after out_ready=1 starts at row_idx=0, col_idx=0.
- Random in_valid gaps (50%) over 20 frames → every out matches a scoreboard of flat index c*ROWS+r.
- Assert rst after 3 elements, then send a full 1..6 frame → out=0x635241 with no leftover elements; all outputs read reset values during rst.
- Edge shapes ROWS=1,COLS=4 and ROWS=4,COLS=1 with values 0xA,0xB,0xC,0xD → out=0xDCBA for both, and the non-varying index stays at 0.
- Macro defined, two frames back-to-back with out_ready=1 → 12 consecutive accepts with no in_ready gap; out=0x635241 then the second frame's value.
